// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns held CPU load/store requests into
// memory strobes, waits for a one-cycle ack (or times out) and returns load
// data with a one-cycle writeback pulse.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              LOAD_WE,
  output logic              BUSYWAIT,
  output logic              ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_ACK
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_write;

  // Stall: pending request in IDLE, or an access in flight; never during reset.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      BUSYWAIT = (state == ACCESS) || ((state == IDLE) && (READ || WRITE));
    end
  end

  // Controller FSM with registered strobes, load data, writeback pulse and error flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      is_write      <= 1'b0;
      READDATA      <= '0;
      LOAD_WE       <= 1'b0;
      ERR           <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      LOAD_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (READ || WRITE) begin
            // Write wins when both are requested; the read is dropped.
            MEM_ADDRESS   <= ADDRESS;
            MEM_WRITEDATA <= WRITEDATA;
            is_write      <= WRITE;
            MEM_WRITE     <= WRITE;
            MEM_READ      <= !WRITE;
            cnt           <= '0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            // Ack beats a simultaneous timeout.
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (!is_write) begin
              READDATA <= MEM_READDATA;
              LOAD_WE  <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            ERR       <= 1'b1;
            if (!is_write) begin
              READDATA <= '0;
              LOAD_WE  <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          READ, WRITE;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] WRITEDATA;
  logic [DW-1:0] READDATA;
  logic          LOAD_WE, BUSYWAIT, ERR, MEM_READ, MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_ACK;

  int total = 0;
  int bad   = 0;
  int cnt_mr = 0, cnt_mw = 0, cnt_lwe = 0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .LOAD_WE(LOAD_WE), .BUSYWAIT(BUSYWAIT), .ERR(ERR),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age = ACCESS cycles elapsed in the current access (0 = none).
  int            m_age;
  logic          m_done, m_wr, m_err, m_lwe;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_age <= 0; m_done <= 1'b0; m_wr <= 1'b0; m_err <= 1'b0; m_lwe <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else begin
      m_lwe <= 1'b0;
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_age == 0) begin
        if (READ || WRITE) begin
          m_age <= 1; m_wr <= WRITE; m_addr <= ADDRESS; m_wdata <= WRITEDATA;
        end
      end else if (MEM_ACK || m_age == int'(TO)) begin
        m_age  <= 0;
        m_done <= 1'b1;
        if (!MEM_ACK) m_err <= 1'b1;
        if (!m_wr) begin
          m_lwe   <= 1'b1;
          m_rdata <= MEM_ACK ? MEM_READDATA : '0;
        end
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic exp_busy;
    exp_busy = !RESET && ((m_age != 0) || (!m_done && (READ || WRITE)));
    chk("readdata",  32'(READDATA), 32'(m_rdata));
    chk("load_we",   32'(LOAD_WE), 32'(m_lwe));
    chk("busywait",  32'(BUSYWAIT), 32'(exp_busy));
    chk("err",       32'(ERR), 32'(m_err));
    chk("mem_read",  32'(MEM_READ), 32'((m_age != 0) && !m_wr));
    chk("mem_write", 32'(MEM_WRITE), 32'((m_age != 0) && m_wr));
    chk("mem_addr",  32'(MEM_ADDRESS), 32'(m_addr));
    chk("mem_wdata", 32'(MEM_WRITEDATA), 32'(m_wdata));
    if (MEM_READ) cnt_mr++;
    if (MEM_WRITE) cnt_mw++;
    if (LOAD_WE) cnt_lwe++;
  end

  // One access from IDLE; ack_edge = ACCESS edge carrying MEM_ACK (0 = never).
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int ack_edge,
                           input logic [DW-1:0] rdata, input logic hold);
    cnt_mr = 0; cnt_mw = 0; cnt_lwe = 0;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    MEM_ACK = 1'b1; MEM_READDATA = 8'hEE;  // ack in IDLE must be ignored
    @(posedge CLK); #1;
    chk("acc_mem_read",  32'(MEM_READ), 32'(rd && !wr));
    chk("acc_mem_write", 32'(MEM_WRITE), 32'(wr));
    chk("acc_mem_addr",  32'(MEM_ADDRESS), 32'(addr));
    chk("acc_mem_wdata", 32'(MEM_WRITEDATA), 32'(wdata));
    for (int i = 1; i <= int'(TO); i++) begin
      MEM_ACK = (i == ack_edge);
      MEM_READDATA = (i == ack_edge) ? rdata : DW'($urandom);
      @(posedge CLK); #1;
      if (i == ack_edge) break;
    end
    chk("done_busywait", 32'(BUSYWAIT), 32'(0));
    chk("done_load_we",  32'(LOAD_WE), 32'(!wr));
    MEM_ACK = 1'b1; MEM_READDATA = 8'hDD;  // ack in DONE must be ignored
    if (!hold) begin READ = 1'b0; WRITE = 1'b0; end
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    MEM_READDATA = '0; MEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mem_read", 32'(MEM_READ), 32'(0));
    chk("rst_err", 32'(ERR), 32'(0));
    chk("rst_readdata", 32'(READDATA), 32'(0));
    chk("rst_busy", 32'(BUSYWAIT), 32'(0));
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Read, ack on 3rd ACCESS edge
    do_access(1'b1, 1'b0, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
    chk("rd_mr_cycles", 32'(cnt_mr), 32'(3));
    chk("rd_lwe_pulses", 32'(cnt_lwe), 32'(1));
    chk("rd_data", 32'(READDATA), 32'hA5);

    // Write, ack after one cycle
    do_access(1'b0, 1'b1, 8'h20, 8'h3C, 1, 8'h77, 1'b0);
    chk("wr_mw_cycles", 32'(cnt_mw), 32'(1));
    chk("wr_lwe_pulses", 32'(cnt_lwe), 32'(0));
    chk("wr_readdata_kept", 32'(READDATA), 32'hA5);

    // Ack on the timeout edge wins
    do_access(1'b1, 1'b0, 8'h55, 8'h00, int'(TO), 8'h99, 1'b0);
    chk("col_mr_cycles", 32'(cnt_mr), 32'(16));
    chk("col_err", 32'(ERR), 32'(0));
    chk("col_data", 32'(READDATA), 32'h99);

    // Read and write together: write only
    do_access(1'b1, 1'b1, 8'h61, 8'h42, 2, 8'h11, 1'b0);
    chk("pri_mr_cycles", 32'(cnt_mr), 32'(0));
    chk("pri_mw_cycles", 32'(cnt_mw), 32'(2));
    chk("pri_lwe_pulses", 32'(cnt_lwe), 32'(0));

    // Read held through DONE restarts in the first IDLE cycle
    do_access(1'b1, 1'b0, 8'h30, 8'h00, 2, 8'h5A, 1'b1);
    chk("b2b_idle_busy", 32'(BUSYWAIT), 32'(1));
    do_access(1'b1, 1'b0, 8'h30, 8'h00, 1, 8'h6B, 1'b0);
    chk("b2b_data", 32'(READDATA), 32'h6B);

    // Timeout on a read
    do_access(1'b1, 1'b0, 8'h40, 8'h00, 0, 8'h00, 1'b0);
    chk("to_mr_cycles", 32'(cnt_mr), 32'(16));
    chk("to_err", 32'(ERR), 32'(1));
    chk("to_data", 32'(READDATA), 32'h00);
    chk("to_lwe_pulses", 32'(cnt_lwe), 32'(1));
    do_access(1'b0, 1'b1, 8'h41, 8'h12, 1, 8'h00, 1'b0);
    chk("to_err_sticky", 32'(ERR), 32'(1));

    // Asynchronous reset in the middle of an access
    cnt_lwe = 0;
    READ = 1'b1; ADDRESS = 8'h44;
    @(posedge CLK); #1;
    repeat (2) begin @(posedge CLK); #1; end
    chk("mid_mem_read_pre", 32'(MEM_READ), 32'(1));
    #3;
    RESET = 1'b1; READ = 1'b0;
    #1;
    chk("mid_mem_read", 32'(MEM_READ), 32'(0));
    chk("mid_busy", 32'(BUSYWAIT), 32'(0));
    chk("mid_load_we", 32'(LOAD_WE), 32'(0));
    chk("mid_err", 32'(ERR), 32'(0));
    chk("mid_mem_addr", 32'(MEM_ADDRESS), 32'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("mid_no_lwe", 32'(cnt_lwe), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
